// File: rtl/hazard_ctrl_if.sv
// Decode/writeback hazard bus between the pipeline datapath (master) and
// the stall/flush sequencer (slave).
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             i_d_vld;
  logic [4:0]       i_d_rs1_addr;
  logic             i_d_rs1_use;
  logic [4:0]       i_d_rs2_addr;
  logic             i_d_rs2_use;
  logic [4:0]       i_d_rd_addr;
  logic             i_d_rd_wren;
  logic             i_d_is_load;
  logic             i_br_taken;
  logic             i_wb_vld;
  logic [4:0]       i_wb_rd_addr;
  logic             i_wb_rd_wren;
  logic             o_stall_f;
  logic             o_stall_d;
  logic             o_flush_d;
  logic             o_flush_e;
  logic             o_issue;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;
  logic             o_err;

  modport slave (
    input  i_d_vld, i_d_rs1_addr, i_d_rs1_use, i_d_rs2_addr, i_d_rs2_use,
           i_d_rd_addr, i_d_rd_wren, i_d_is_load, i_br_taken,
           i_wb_vld, i_wb_rd_addr, i_wb_rd_wren,
    output o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_issue,
           o_state, o_stall_cnt, o_flush_cnt, o_err
  );

  modport master (
    output i_d_vld, i_d_rs1_addr, i_d_rs1_use, i_d_rs2_addr, i_d_rs2_use,
           i_d_rd_addr, i_d_rd_wren, i_d_is_load, i_br_taken,
           i_wb_vld, i_wb_rd_addr, i_wb_rd_wren,
    input  o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_issue,
           o_state, o_stall_cnt, o_flush_cnt, o_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage RV32I pipeline: per-register in-flight
// write scoreboard, load-use / RAW stall decision and post-redirect bubbles.
module hazard_ctrl #(
  parameter bit          FWD_EN    = 1'b1,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int          CNT_W     = 32
) (
  input logic          i_clk,
  input logic          i_rst_n,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {ST_RUN = 2'b00, ST_STALL = 2'b01, ST_FLUSH = 2'b10} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [1:0]       remain_reg, remain_next;
  logic             last_load_reg, last_load_next;
  logic [4:0]       last_rd_reg, last_rd_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic             err_reg, err_next;

  logic [63:0] pend_flat;
  logic [31:1] ovf, unf;
  logic [1:0]  pend_rs1, pend_rs2;
  logic        wb_hit, sb_inc, rs1_haz, rs2_haz, hazard, redirect;
  logic        stall_f, stall_d, flush_d, flush_e, issue;

  assign wb_hit   = bus.i_wb_vld && bus.i_wb_rd_wren && (bus.i_wb_rd_addr != 5'd0);
  assign sb_inc   = issue && bus.i_d_rd_wren && (bus.i_d_rd_addr != 5'd0);
  assign pend_rs1 = pend_flat[{bus.i_d_rs1_addr, 1'b0} +: 2];
  assign pend_rs2 = pend_flat[{bus.i_d_rs2_addr, 1'b0} +: 2];

  // x0 has no scoreboard entry; its slot reads as permanently idle.
  assign pend_flat[1:0] = 2'b00;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_pend
      logic [1:0] pend_reg, pend_next;
      logic       inc, dec;

      assign inc = sb_inc && (bus.i_d_rd_addr == 5'(gi));
      assign dec = wb_hit && (bus.i_wb_rd_addr == 5'(gi));
      assign ovf[gi] = inc && !dec && (pend_reg == 2'd3);
      assign unf[gi] = dec && !inc && (pend_reg == 2'd0);
      assign pend_flat[2*gi +: 2] = pend_reg;

      always_comb begin
        pend_next = pend_reg;
        if (inc && !dec && pend_reg != 2'd3)
          pend_next = pend_reg + 2'd1;
        else if (dec && !inc && pend_reg != 2'd0)
          pend_next = pend_reg - 2'd1;
      end

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) pend_reg <= 2'd0;
        else          pend_reg <= pend_next;
      end
    end
  endgenerate

  // A write retiring this cycle is visible to the same-cycle regfile read.
  always_comb begin
    rs1_haz = 1'b0;
    rs2_haz = 1'b0;
    if (FWD_EN) begin
      rs1_haz = last_load_reg && (last_rd_reg == bus.i_d_rs1_addr);
      rs2_haz = last_load_reg && (last_rd_reg == bus.i_d_rs2_addr);
    end else begin
      rs1_haz = (pend_rs1 != 2'd0) &&
                !(wb_hit && bus.i_wb_rd_addr == bus.i_d_rs1_addr && pend_rs1 == 2'd1);
      rs2_haz = (pend_rs2 != 2'd0) &&
                !(wb_hit && bus.i_wb_rd_addr == bus.i_d_rs2_addr && pend_rs2 == 2'd1);
    end
    rs1_haz = rs1_haz && bus.i_d_rs1_use && (bus.i_d_rs1_addr != 5'd0);
    rs2_haz = rs2_haz && bus.i_d_rs2_use && (bus.i_d_rs2_addr != 5'd0);
  end

  assign hazard   = bus.i_d_vld && (rs1_haz || rs2_haz);
  assign redirect = bus.i_br_taken || (state_reg == ST_FLUSH && remain_reg != 2'd0);

  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    issue       = 1'b0;

    if (!i_rst_n || redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (hazard) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      issue = bus.i_d_vld;
    end

    case (state_reg)
      ST_RUN, ST_STALL: begin
        if (bus.i_br_taken) begin
          state_next  = ST_FLUSH;
          remain_next = 2'(FLUSH_CYC);
        end else if (hazard) begin
          state_next = ST_STALL;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (bus.i_br_taken)
          remain_next = 2'(FLUSH_CYC);
        else if (remain_reg != 2'd0)
          remain_next = remain_reg - 2'd1;
        else
          state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (hazard && !redirect && stall_cnt_reg != CNT_MAX)
      stall_cnt_next = stall_cnt_reg + CNT_ONE;
    if (bus.i_br_taken && flush_cnt_reg != CNT_MAX)
      flush_cnt_next = flush_cnt_reg + CNT_ONE;
    err_next       = err_reg || (|ovf) || (|unf);
    last_load_next = issue && bus.i_d_is_load && (bus.i_d_rd_addr != 5'd0);
    last_rd_next   = bus.i_d_rd_addr;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= ST_RUN;
      remain_reg    <= 2'd0;
      last_load_reg <= 1'b0;
      last_rd_reg   <= 5'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remain_reg    <= remain_next;
      last_load_reg <= last_load_next;
      last_rd_reg   <= last_rd_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      err_reg       <= err_next;
    end
  end

  assign bus.o_stall_f   = stall_f;
  assign bus.o_stall_d   = stall_d;
  assign bus.o_flush_d   = flush_d;
  assign bus.o_flush_e   = flush_e;
  assign bus.o_issue     = issue;
  assign bus.o_state     = state_reg;
  assign bus.o_stall_cnt = stall_cnt_reg;
  assign bus.o_flush_cnt = flush_cnt_reg;
  assign bus.o_err       = err_reg;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (no forwarding / full forwarding)
// share one stimulus stream; a behavioural model queues expectations, a monitor checks.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n;
    logic       d_vld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wren;
    logic       ld;
    logic       br;
    logic       wb_vld;
    logic [4:0] wb_rd;
    logic       wb_wren;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [4:0]  ctrl[2];   // {stall_f, stall_d, flush_d, flush_e, issue}
    logic [1:0]  st[2];
    logic [31:0] sc[2];
    logic [31:0] fc[2];
    logic        err[2];
  } exp_t;

  stim_t cur = '0;
  logic  rst_n;
  assign rst_n = cur.rst_n;

  hazard_ctrl_if #(.CNT_W(32)) bus_a ();
  hazard_ctrl_if #(.CNT_W(4))  bus_b ();

  assign bus_a.i_d_vld      = cur.d_vld;   assign bus_b.i_d_vld      = cur.d_vld;
  assign bus_a.i_d_rs1_addr = cur.rs1;     assign bus_b.i_d_rs1_addr = cur.rs1;
  assign bus_a.i_d_rs1_use  = cur.u1;      assign bus_b.i_d_rs1_use  = cur.u1;
  assign bus_a.i_d_rs2_addr = cur.rs2;     assign bus_b.i_d_rs2_addr = cur.rs2;
  assign bus_a.i_d_rs2_use  = cur.u2;      assign bus_b.i_d_rs2_use  = cur.u2;
  assign bus_a.i_d_rd_addr  = cur.rd;      assign bus_b.i_d_rd_addr  = cur.rd;
  assign bus_a.i_d_rd_wren  = cur.wren;    assign bus_b.i_d_rd_wren  = cur.wren;
  assign bus_a.i_d_is_load  = cur.ld;      assign bus_b.i_d_is_load  = cur.ld;
  assign bus_a.i_br_taken   = cur.br;      assign bus_b.i_br_taken   = cur.br;
  assign bus_a.i_wb_vld     = cur.wb_vld;  assign bus_b.i_wb_vld     = cur.wb_vld;
  assign bus_a.i_wb_rd_addr = cur.wb_rd;   assign bus_b.i_wb_rd_addr = cur.wb_rd;
  assign bus_a.i_wb_rd_wren = cur.wb_wren; assign bus_b.i_wb_rd_wren = cur.wb_wren;

  hazard_ctrl #(.FWD_EN(1'b0), .FLUSH_CYC(2), .CNT_W(32)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a.slave));
  hazard_ctrl #(.FWD_EN(1'b1), .FLUSH_CYC(1), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b.slave));

  // Reference model: instance 0 = no forwarding, 2 redirect bubbles, 32-bit counters;
  // instance 1 = full forwarding, 1 bubble, 4-bit counters.
  int     fwd_p[2]  = '{0, 1};
  int     fcyc_p[2] = '{2, 1};
  longint cmax_p[2] = '{64'hFFFF_FFFF, 15};
  int     pend_m[2][32];
  int     mode_m[2];     // 0 run, 1 stall, 2 flush
  int     left_m[2];
  int     ldrd_m[2];     // destination of a load issued last cycle, -1 if none
  longint scnt_m[2], fcnt_m[2];
  bit     err_m[2];

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  task automatic model_reset(input int k);
    for (int r = 0; r < 32; r++) pend_m[k][r] = 0;
    mode_m[k] = 0; left_m[k] = 0; ldrd_m[k] = -1;
    scnt_m[k] = 0; fcnt_m[k] = 0; err_m[k] = 1'b0;
  endtask

  function automatic bit src_haz(input int k, input bit use_s, input int rs, input stim_t s);
    bit wb_clear;
    if (!use_s || rs == 0) return 1'b0;
    if (fwd_p[k] != 0) return ldrd_m[k] == rs;
    wb_clear = s.wb_vld && s.wb_wren && int'(s.wb_rd) == rs && pend_m[k][rs] == 1;
    return pend_m[k][rs] > 0 && !wb_clear;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    cur = s;
    e.cyc = cyc;
    for (int k = 0; k < 2; k++) begin
      bit redirect, hazard, issue;
      int inc_r, dec_r;
      e.st[k]  = 2'(mode_m[k]);
      e.sc[k]  = 32'(scnt_m[k]);
      e.fc[k]  = 32'(fcnt_m[k]);
      e.err[k] = err_m[k];
      if (!s.rst_n) begin
        e.ctrl[k] = 5'b00110;
        model_reset(k);
      end else begin
        redirect = s.br || (mode_m[k] == 2 && left_m[k] > 0);
        hazard   = s.d_vld && (src_haz(k, s.u1, int'(s.rs1), s) || src_haz(k, s.u2, int'(s.rs2), s));
        issue    = !redirect && !hazard && s.d_vld;
        e.ctrl[k] = redirect ? 5'b00110 : hazard ? 5'b11010 : {4'b0000, issue};
        inc_r = (issue && s.wren && s.rd != 0) ? int'(s.rd) : -1;
        dec_r = (s.wb_vld && s.wb_wren && s.wb_rd != 0) ? int'(s.wb_rd) : -1;
        if (inc_r != dec_r) begin
          if (inc_r > 0) begin
            if (pend_m[k][inc_r] == 3) err_m[k] = 1'b1;
            else pend_m[k][inc_r]++;
          end
          if (dec_r > 0) begin
            if (pend_m[k][dec_r] == 0) err_m[k] = 1'b1;
            else pend_m[k][dec_r]--;
          end
        end
        if (hazard && !redirect && scnt_m[k] < cmax_p[k]) scnt_m[k]++;
        if (s.br && fcnt_m[k] < cmax_p[k]) fcnt_m[k]++;
        if (s.br) begin
          mode_m[k] = 2; left_m[k] = fcyc_p[k];
        end else if (mode_m[k] == 2) begin
          if (left_m[k] > 0) left_m[k]--;
          else mode_m[k] = 0;
        end else begin
          mode_m[k] = hazard ? 1 : 0;
        end
        ldrd_m[k] = (issue && s.ld && s.rd != 0) ? int'(s.rd) : -1;
      end
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic chk(input string name, input int k, input int c,
                     input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, k, c, act, expv);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl",  0, e.cyc, 32'({bus_a.o_stall_f, bus_a.o_stall_d, bus_a.o_flush_d,
                                    bus_a.o_flush_e, bus_a.o_issue}), 32'(e.ctrl[0]));
        chk("state", 0, e.cyc, 32'(bus_a.o_state), 32'(e.st[0]));
        chk("stall_cnt", 0, e.cyc, bus_a.o_stall_cnt, e.sc[0]);
        chk("flush_cnt", 0, e.cyc, bus_a.o_flush_cnt, e.fc[0]);
        chk("err",   0, e.cyc, 32'(bus_a.o_err), 32'(e.err[0]));
        chk("ctrl",  1, e.cyc, 32'({bus_b.o_stall_f, bus_b.o_stall_d, bus_b.o_flush_d,
                                    bus_b.o_flush_e, bus_b.o_issue}), 32'(e.ctrl[1]));
        chk("state", 1, e.cyc, 32'(bus_b.o_state), 32'(e.st[1]));
        chk("stall_cnt", 1, e.cyc, 32'(bus_b.o_stall_cnt), e.sc[1]);
        chk("flush_cnt", 1, e.cyc, 32'(bus_b.o_flush_cnt), e.fc[1]);
        chk("err",   1, e.cyc, 32'(bus_b.o_err), 32'(e.err[1]));
      end
    end
  end

  function automatic stim_t nop();
    stim_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t instr(input int rs1, input bit u1, input int rs2, input bit u2,
                                  input int rd, input bit wren, input bit ld);
    stim_t s = nop();
    s.d_vld = 1'b1;
    s.rs1 = 5'(rs1); s.u1 = u1; s.rs2 = 5'(rs2); s.u2 = u2;
    s.rd = 5'(rd); s.wren = wren; s.ld = ld;
    return s;
  endfunction

  function automatic stim_t wb(input int rd);
    stim_t s = nop();
    s.wb_vld = 1'b1; s.wb_wren = 1'b1; s.wb_rd = 5'(rd);
    return s;
  endfunction

  stim_t rst_s;

  initial begin
    stim_t s;
    rst_s = '0;
    cur = rst_s;
    repeat (2) @(posedge clk);
    model_reset(0);
    model_reset(1);

    // Reset taken in the middle of a stall
    step(rst_s);
    step(instr(0, 0, 0, 0, 5, 1, 0));
    s = instr(5, 1, 0, 0, 6, 1, 0);
    step(s); step(s);
    s.rst_n = 1'b0; step(s);
    step(instr(5, 1, 0, 0, 6, 1, 0));

    // Load-use on the forwarding instance, RAW stall on the other
    step(rst_s);
    step(instr(0, 0, 0, 0, 5, 1, 1));
    s = instr(5, 1, 0, 0, 6, 1, 0);
    step(s); step(s);
    step(wb(5)); step(wb(6));

    // Dependent instruction issues in the cycle its producer retires
    step(rst_s);
    step(instr(1, 1, 2, 1, 3, 1, 0));
    s = instr(3, 1, 1, 1, 4, 1, 0);
    step(s); step(s);
    s.wb_vld = 1'b1; s.wb_wren = 1'b1; s.wb_rd = 5'd3;
    step(s);
    step(nop());

    // Redirect while a hazard is pending
    step(rst_s);
    step(instr(0, 0, 0, 0, 8, 1, 1));
    s = instr(8, 1, 0, 0, 9, 1, 0);
    s.br = 1'b1; step(s);
    s.br = 1'b0; step(s); step(s); step(s);

    // x0 never tracked
    step(rst_s);
    step(instr(0, 1, 0, 0, 0, 1, 1));
    step(instr(0, 1, 0, 1, 1, 1, 0));
    step(nop());

    // Scoreboard saturation and underflow, sticky error
    step(rst_s);
    repeat (4) step(instr(0, 0, 0, 0, 7, 1, 0));
    repeat (5) step(wb(7));
    step(nop());

    for (int i = 0; i < 3000; i++) begin
      s.rst_n   = ($urandom_range(0, 99) != 0);
      s.d_vld   = ($urandom_range(0, 3) != 0);
      s.rs1     = 5'($urandom_range(0, 7));
      s.u1      = 1'($urandom);
      s.rs2     = 5'($urandom_range(0, 7));
      s.u2      = 1'($urandom);
      s.rd      = 5'($urandom_range(0, 7));
      s.wren    = ($urandom_range(0, 3) != 0);
      s.ld      = ($urandom_range(0, 2) == 0);
      s.br      = ($urandom_range(0, 9) == 0);
      s.wb_vld  = ($urandom_range(0, 2) == 0);
      s.wb_rd   = 5'($urandom_range(0, 7));
      s.wb_wren = 1'($urandom);
      step(s);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule
